// File: rtl/pong_frame_sched.sv
// Per-frame pong scheduler: latches the newest UART paddle word and runs
// load/move/collide/commit once per vsync fall so render only sees frame-coherent state.
module pong_frame_sched #(
    parameter int COORDWID = 16,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PADDLE_W = 8,
    parameter int PADDLE_H = 64,
    parameter int BALL_SZ  = 8,
    parameter int BALL_SPD = 2
) (
    input  logic                i_clk,
    input  logic                n_btn_rst,
    input  logic                n_vsync,
    input  logic                valid_data,
    input  logic [31:0]         uart_buf,
    output logic [31:0]         render_pos,
    output logic [COORDWID-1:0] ball_x,
    output logic [COORDWID-1:0] ball_y,
    output logic [7:0]          score,
    output logic                frame_done
);
    localparam int CW1 = COORDWID + 1;

    localparam logic [15:0]    PAD_MAX = 16'(V_RES - PADDLE_H);
    localparam logic [15:0]    PAD_RST = 16'((V_RES - PADDLE_H) / 2);
    localparam logic [CW1-1:0] CTR_X   = CW1'(H_RES / 2 - BALL_SZ / 2);
    localparam logic [CW1-1:0] CTR_Y   = CW1'(V_RES / 2 - BALL_SZ / 2);
    localparam logic [CW1-1:0] SPD     = CW1'(BALL_SPD);
    localparam logic [CW1-1:0] BSZ     = CW1'(BALL_SZ);
    localparam logic [CW1-1:0] PW      = CW1'(PADDLE_W);
    localparam logic [CW1-1:0] PH      = CW1'(PADDLE_H);
    localparam logic [CW1-1:0] VRES    = CW1'(V_RES);
    localparam logic [CW1-1:0] BY_MAX  = CW1'(V_RES - BALL_SZ);
    localparam logic [CW1-1:0] R_EDGE  = CW1'(H_RES - PADDLE_W);
    localparam logic [CW1-1:0] BX_RHIT = CW1'(H_RES - PADDLE_W - BALL_SZ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_COLLIDE,
        S_COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic                 vs_q, vs_d;
    logic [31:0]          pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [15:0]          p1_q, p1_d, p2_q, p2_d;
    logic [CW1-1:0]       bx_q, bx_d, by_q, by_d;
    logic                 dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [3:0]           s1_q, s1_d, s2_q, s2_d;
    logic [31:0]          rpos_q, rpos_d;
    logic [COORDWID-1:0]  bxo_q, bxo_d, byo_q, byo_d;
    logic [7:0]           score_q, score_d;
    logic                 fdone_q, fdone_d;

    logic [CW1-1:0]       p1_x, p2_x, by_v;
    logic                 dyn_v, at_left, at_right, hit_l, hit_r;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    function automatic logic [15:0] clamp_pad(input logic [15:0] p);
        return (p > PAD_MAX) ? PAD_MAX : p;
    endfunction

    // Vertical bounce is resolved first; the paddle overlap test uses the resolved row.
    always_comb begin
        p1_x  = CW1'(p1_q);
        p2_x  = CW1'(p2_q);
        by_v  = by_q;
        dyn_v = dy_neg_q;
        if (by_q[CW1-1]) begin
            by_v  = '0;
            dyn_v = 1'b0;
        end else if (by_q + BSZ >= VRES) begin
            by_v  = BY_MAX;
            dyn_v = 1'b1;
        end
        at_left  = dx_neg_q && (bx_q[CW1-1] || bx_q <= PW);
        at_right = !dx_neg_q && (bx_q + BSZ >= R_EDGE);
        hit_l    = (by_v + BSZ > p1_x) && (by_v < p1_x + PH);
        hit_r    = (by_v + BSZ > p2_x) && (by_v < p2_x + PH);
    end

    always_comb begin
        state_d    = state_q;
        vs_d       = n_vsync;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_neg_d   = dx_neg_q;
        dy_neg_d   = dy_neg_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        rpos_d     = rpos_q;
        bxo_d      = bxo_q;
        byo_d      = byo_q;
        score_d    = score_q;
        fdone_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (vs_q && !n_vsync) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (pend_vld_q) begin
                    p1_d = clamp_pad(pend_q[31:16]);
                    p2_d = clamp_pad(pend_q[15:0]);
                end
                pend_vld_d = 1'b0;
                state_d    = S_MOVE;
            end
            S_MOVE: begin
                bx_d    = dx_neg_q ? bx_q - SPD : bx_q + SPD;
                by_d    = dy_neg_q ? by_q - SPD : by_q + SPD;
                state_d = S_COLLIDE;
            end
            S_COLLIDE: begin
                by_d     = by_v;
                dy_neg_d = dyn_v;
                if (at_left) begin
                    dx_neg_d = 1'b0;
                    if (hit_l) begin
                        bx_d = PW;
                    end else begin
                        s2_d = sat_inc(s2_q);
                        bx_d = CTR_X;
                        by_d = CTR_Y;
                    end
                end else if (at_right) begin
                    dx_neg_d = 1'b1;
                    if (hit_r) begin
                        bx_d = BX_RHIT;
                    end else begin
                        s1_d = sat_inc(s1_q);
                        bx_d = CTR_X;
                        by_d = CTR_Y;
                    end
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                rpos_d  = {p1_q, p2_q};
                bxo_d   = bx_q[COORDWID-1:0];
                byo_d   = by_q[COORDWID-1:0];
                score_d = {s1_q, s2_q};
                fdone_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe landing in the LOAD cycle survives the clear and feeds the next frame.
        if (valid_data) begin
            pend_d     = uart_buf;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!n_btn_rst) begin
            state_q    <= S_IDLE;
            vs_q       <= 1'b1;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            p1_q       <= PAD_RST;
            p2_q       <= PAD_RST;
            bx_q       <= CTR_X;
            by_q       <= CTR_Y;
            dx_neg_q   <= 1'b0;
            dy_neg_q   <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            rpos_q     <= {PAD_RST, PAD_RST};
            bxo_q      <= CTR_X[COORDWID-1:0];
            byo_q      <= CTR_Y[COORDWID-1:0];
            score_q    <= '0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_neg_q   <= dx_neg_d;
            dy_neg_q   <= dy_neg_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rpos_q     <= rpos_d;
            bxo_q      <= bxo_d;
            byo_q      <= byo_d;
            score_q    <= score_d;
            fdone_q    <= fdone_d;
        end
    end

    assign render_pos = rpos_q;
    assign ball_x     = bxo_q;
    assign ball_y     = byo_q;
    assign score      = score_q;
    assign frame_done = fdone_q;

endmodule
